freq_meter: RTL and testbench

Gated edge-counting frequency meter. It measures the frequency of an asynchronous single-bit signal, such as an on-chip oscillator output, a PLL output divided down, or an external pin, against the design's system clock. Each gate window produces one count result, a valid strobe, and a range-check flag. The range-check flag drives LEDs or lock/health logic that sits next to the clock-generation blocks.

---
 rtl/freq_meter.sv | 174 +++++++++++++++++
 tb/tb_freq_meter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// Gated edge-counting frequency meter.
//
// Counts rising edges of an asynchronous input over a window of GATE_CYCLES
// clk cycles and reports the result with a one-cycle valid strobe. Windows run
// back to back while en is high.
//
// Ports:
//   clk        system clock (single domain)
//   rst        synchronous active-high reset
//   en         measurement enable
//   sig_in     asynchronous signal under measurement
//   lo_thr     inclusive lower bound for in_range, sampled at window close
//   hi_thr     inclusive upper bound for in_range, sampled at window close
//   freq_count rising edges counted in the last completed window (saturating)
//   valid      one-cycle strobe when a new result is loaded
//   overflow   last completed window saturated its count
//   in_range   lo_thr <= freq_count <= hi_thr for the last completed window
//   busy       high whenever the meter is not idle
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 12000000,
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  input  logic [CNT_W-1:0] lo_thr,
  input  logic [CNT_W-1:0] hi_thr,
  output logic [CNT_W-1:0] freq_count,
  output logic             valid,
  output logic             overflow,
  output logic             in_range,
  output logic             busy
);

  localparam int unsigned GateW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int unsigned ArmW  = $clog2(SYNC_STAGES + 1);
  localparam logic [GateW-1:0] GateLast = GateW'(GATE_CYCLES - 1);
  localparam logic [ArmW-1:0]  ArmLast  = ArmW'(SYNC_STAGES);
  localparam logic [CNT_W-1:0] CntMax   = '1;

  typedef enum logic [1:0] {StIdle, StArm, StGate} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [ArmW-1:0]        arm_cnt_q, arm_cnt_d;
  logic [GateW-1:0]       gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]       edge_cnt_q, edge_cnt_d;
  logic                   sat_q, sat_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   valid_q, valid_d;
  logic                   ovf_q, ovf_d;
  logic                   inr_q, inr_d;
  logic                   busy_q, busy_d;

  logic                   edge_det;
  logic [CNT_W-1:0]       cnt_inc;
  logic                   sat_inc;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], sig_in};
    prev_d   = sync_q[SYNC_STAGES-1];
    edge_det = sync_q[SYNC_STAGES-1] & ~prev_q;

    // Count including this cycle's edge; an edge at full scale marks saturation.
    cnt_inc = edge_cnt_q;
    sat_inc = sat_q;
    if (edge_det) begin
      if (edge_cnt_q == CntMax) begin
        sat_inc = 1'b1;
      end else begin
        cnt_inc = edge_cnt_q + 1'b1;
      end
    end

    state_d    = state_q;
    arm_cnt_d  = arm_cnt_q;
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    sat_d      = sat_q;
    count_d    = count_q;
    valid_d    = 1'b0;
    ovf_d      = ovf_q;
    inr_d      = inr_q;

    unique case (state_q)
      StIdle: begin
        arm_cnt_d  = '0;
        gate_cnt_d = '0;
        edge_cnt_d = '0;
        sat_d      = 1'b0;
        if (en) state_d = StArm;
      end
      // Edges are ignored here so a level that is already high is not counted.
      StArm: begin
        if (!en) begin
          state_d   = StIdle;
          arm_cnt_d = '0;
        end else if (arm_cnt_q == ArmLast) begin
          state_d    = StGate;
          arm_cnt_d  = '0;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          sat_d      = 1'b0;
        end else begin
          arm_cnt_d = arm_cnt_q + 1'b1;
        end
      end
      StGate: begin
        if (!en) begin
          // Partial window is discarded; results stay untouched.
          state_d    = StIdle;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          sat_d      = 1'b0;
        end else if (gate_cnt_q == GateLast) begin
          count_d    = cnt_inc;
          ovf_d      = sat_inc;
          inr_d      = (lo_thr <= cnt_inc) && (cnt_inc <= hi_thr);
          valid_d    = 1'b1;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          sat_d      = 1'b0;
        end else begin
          gate_cnt_d = gate_cnt_q + 1'b1;
          edge_cnt_d = cnt_inc;
          sat_d      = sat_inc;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      sync_q     <= '0;
      prev_q     <= 1'b0;
      arm_cnt_q  <= '0;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      sat_q      <= 1'b0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      inr_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      arm_cnt_q  <= arm_cnt_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      sat_q      <= sat_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      inr_q      <= inr_d;
      busy_q     <= busy_d;
    end
  end

  assign freq_count = count_q;
  assign valid      = valid_q;
  assign overflow   = ovf_q;
  assign in_range   = inr_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_freq_meter.sv
module tb_freq_meter;
  localparam int Gate = 100;

  logic       clk = 1'b0;
  logic       rst, en, sig_in;
  logic [7:0] lo_thr, hi_thr;
  logic [7:0] f8;
  logic       v8, o8, r8, b8;
  logic [3:0] f4;
  logic       v4, o4, r4, b4;

  freq_meter #(.GATE_CYCLES(Gate), .CNT_W(8), .SYNC_STAGES(2)) u_dut8 (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in), .lo_thr(lo_thr), .hi_thr(hi_thr),
    .freq_count(f8), .valid(v8), .overflow(o8), .in_range(r8), .busy(b8)
  );

  freq_meter #(.GATE_CYCLES(Gate), .CNT_W(4), .SYNC_STAGES(2)) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in), .lo_thr(lo_thr[3:0]),
    .hi_thr(hi_thr[3:0]), .freq_count(f4), .valid(v4), .overflow(o4), .in_range(r4),
    .busy(b4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Stimulus generator: 0 constant level, 1 square wave, 2 scripted samples.
  int mode = 0;
  bit lvl  = 1'b0;
  int per  = 10;
  int ph   = 0;
  bit sc [16384];
  bit s_log [16384];

  // Reference model state: a window is open from g0 while running.
  bit running = 1'b0;
  int g0      = 0;

  typedef struct {int due; int cnt; bit ovf; bit inr;} exp_t;
  exp_t q8[$];
  exp_t q4[$];
  exp_t last8, last4;
  int   got8[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Rising edges seen by the detector during cycles first..last: the detector
  // sees the input sample from two cycles earlier, compared with the one before.
  function automatic int edges_in(input int first, input int last);
    int n = 0;
    for (int c = first; c <= last; c++) begin
      if (c >= 3 && s_log[c-2] && !s_log[c-3]) n++;
    end
    return n;
  endfunction

  function automatic exp_t make_exp(input int n, input int maxv, input int lo, input int hi);
    exp_t e;
    e.due = cyc + 1;
    e.cnt = (n > maxv) ? maxv : n;
    e.ovf = (n > maxv);
    e.inr = (lo <= e.cnt) && (e.cnt <= hi);
    return e;
  endfunction

  // Model: log the sample, and on each window close push the expected result.
  always @(negedge clk) begin
    s_log[cyc] = sig_in;
    if (running && cyc >= g0 + Gate - 1 && ((cyc - g0) % Gate) == Gate - 1) begin
      int n;
      n = edges_in(cyc - Gate + 1, cyc);
      q8.push_back(make_exp(n, 255, int'(lo_thr), int'(hi_thr)));
      q4.push_back(make_exp(n, 15, int'(lo_thr[3:0]), int'(hi_thr[3:0])));
    end
  end

  // Monitors.
  always @(negedge clk) begin
    exp_t e;
    if (v8) begin
      got8.push_back(int'(f8));
      if (q8.size() == 0) chk("dut8 unexpected valid", int'(v8), 0);
      else begin
        e = q8.pop_front();
        chk("dut8 valid cycle", cyc, e.due);
        chk("dut8 freq_count", int'(f8), e.cnt);
        chk("dut8 overflow", int'(o8), int'(e.ovf));
        chk("dut8 in_range", int'(r8), int'(e.inr));
        last8 = e;
      end
    end
    if (q8.size() > 0 && cyc > q8[0].due) begin
      chk("dut8 missed valid", int'(v8), 1);
      void'(q8.pop_front());
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (v4) begin
      if (q4.size() == 0) chk("dut4 unexpected valid", int'(v4), 0);
      else begin
        e = q4.pop_front();
        chk("dut4 valid cycle", cyc, e.due);
        chk("dut4 freq_count", int'(f4), e.cnt);
        chk("dut4 overflow", int'(o4), int'(e.ovf));
        chk("dut4 in_range", int'(r4), int'(e.inr));
        last4 = e;
      end
    end
    if (q4.size() > 0 && cyc > q4[0].due) begin
      chk("dut4 missed valid", int'(v4), 1);
      void'(q4.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    case (mode)
      0:       sig_in = lvl;
      1:       sig_in = (((cyc - ph) % per) < per / 2);
      default: sig_in = sc[cyc];
    endcase
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic start_meas();
    chk("busy low before en", int'(b8), 0);
    en      = 1'b1;
    running = 1'b1;
    g0      = cyc + 4;
    tick();
    chk("busy high after en", int'(b8), 1);
    chk("busy4 high after en", int'(b4), 1);
  endtask

  task automatic stop_meas();
    en      = 1'b0;
    running = 1'b0;
  endtask

  task automatic check_held(input string tag);
    chk({tag, " dut8 count held"}, int'(f8), last8.cnt);
    chk({tag, " dut8 ovf held"}, int'(o8), int'(last8.ovf));
    chk({tag, " dut8 in_range held"}, int'(r8), int'(last8.inr));
    chk({tag, " dut4 count held"}, int'(f4), last4.cnt);
    chk({tag, " busy low"}, int'(b8), 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " freq_count"}, int'(f8), 0);
    chk({tag, " valid"}, int'(v8), 0);
    chk({tag, " overflow"}, int'(o8), 0);
    chk({tag, " in_range"}, int'(r8), 0);
    chk({tag, " busy"}, int'(b8), 0);
    chk({tag, " dut4 count"}, int'(f4), 0);
    chk({tag, " dut4 busy"}, int'(b4), 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sig_in = 1'b0; lo_thr = 8'd0; hi_thr = 8'd255;
    last8 = '{0, 0, 1'b0, 1'b0};
    last4 = '{0, 0, 1'b0, 1'b0};
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b0;
    tick();

    // Steady square wave, period 10.
    mode = 1; per = 10; ph = cyc; lo_thr = 8'd9; hi_thr = 8'd11;
    start_meas();
    run_to(g0 + 3 * Gate + 50);
    stop_meas();
    repeat (5) tick();

    // Static levels before en: the arm flush must not produce an edge.
    for (int l = 1; l >= 0; l--) begin
      mode = 0; lvl = bit'(l);
      repeat (10) tick();
      start_meas();
      run_to(g0 + Gate + 50);
      stop_meas();
      repeat (5) tick();
    end

    // Saturation in the 4-bit meter, then a slower input.
    mode = 1; per = 4; ph = cyc; lo_thr = 8'd0; hi_thr = 8'd14;
    start_meas();
    run_to(g0 + Gate);
    per = 20; ph = cyc;
    run_to(g0 + 2 * Gate + 50);
    stop_meas();
    repeat (5) tick();

    // Edges on the close cycle and on the first cycle of a later window.
    begin
      int c0, c1;
      mode = 2;
      foreach (sc[i]) sc[i] = 1'b0;
      c0 = cyc + 103;
      c1 = c0 + Gate;
      for (int i = 0; i < 5; i++) begin
        sc[c0 - 2 + i] = 1'b1;
        sc[c1 - 1 + i] = 1'b1;
      end
      got8.delete();
      start_meas();
      // Dropping en at gate cycle 50 of the fourth window discards it.
      run_to(g0 + 3 * Gate + 50);
      stop_meas();
      chk("boundary windows seen", got8.size(), 3);
      if (got8.size() == 3) begin
        chk("boundary window N", got8[0], 1);
        chk("boundary window N+1", got8[1], 0);
        chk("boundary window N+2", got8[2], 1);
      end
      repeat (3) tick();
      check_held("en drop");
      repeat (150) tick();
      check_held("en drop late");
    end

    // Re-arm after the drop; first valid due 1+3+100 cycles after en.
    mode = 1; per = 8; ph = cyc;
    start_meas();
    run_to(g0 + Gate + 30);

    // Reset mid-window with en held high, and an inverted threshold pair.
    lo_thr = 8'd20; hi_thr = 8'd10; per = 10; ph = cyc;
    run_to(g0 + 2 * Gate + 30);
    rst = 1'b1;
    running = 1'b0;
    tick();
    check_zero("mid-window rst");
    last8 = '{0, 0, 1'b0, 1'b0};
    last4 = '{0, 0, 1'b0, 1'b0};
    rst = 1'b0;
    running = 1'b1;
    g0 = cyc + 4;
    run_to(g0 + 2 * Gate + 50);
    stop_meas();
    repeat (5) tick();

    // Randomized periods and thresholds, thresholds also moved mid-window.
    for (int r = 0; r < 4; r++) begin
      mode = 1; per = $urandom_range(4, 40); ph = cyc;
      lo_thr = 8'($urandom_range(0, 40)); hi_thr = 8'($urandom_range(0, 40));
      start_meas();
      while (cyc < g0 + 2 * Gate + 10 + $urandom_range(0, 70)) begin
        tick();
        if ($urandom_range(0, 49) == 0) begin
          lo_thr = 8'($urandom_range(0, 40));
          hi_thr = 8'($urandom_range(0, 40));
        end
      end
      stop_meas();
      repeat (5) tick();
    end

    repeat (5) tick();
    chk("scoreboard drained", q8.size() + q4.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
